// File: rtl/fft32_frame_sequencer_pkg.sv
// fft_pkg: shared widths and load-state encoding for the FFT frame sequencer
package fft_pkg;
  localparam int FFT_N      = 16;
  localparam int FFT_Q      = 8;
  localparam int FFT_POINTS = 32;
  localparam int FFT_IDX_W  = 5;
  typedef enum logic [1:0] {FILL, HOLD, SETTLE, CAPTURE} load_state_e;
endpackage

// File: rtl/fft32_frame_sequencer_unloader.sv
// fft_result_unloader: holds captured FFT bins and streams them out in index order
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int POINTS = FFT_POINTS,
  parameter int IDX_W  = FFT_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_capture,
  input  logic [POINTS*N-1:0] i_yr,
  input  logic [POINTS*N-1:0] i_yi,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [N-1:0]        o_re,
  output logic [N-1:0]        o_im,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_last,
  output logic [15:0]         o_frames
);
  logic [POINTS-1:0][N-1:0] r_re;
  logic [POINTS-1:0][N-1:0] r_im;
  logic                     r_busy;
  logic [IDX_W-1:0]         r_idx;
  logic [15:0]              r_frames;
  logic                     w_last;
  assign w_last   = r_idx == IDX_W'(POINTS - 1);
  assign o_valid  = r_busy;
  assign o_re     = r_re[r_idx];
  assign o_im     = r_im[r_idx];
  assign o_idx    = r_idx;
  assign o_last   = r_busy && w_last;
  assign o_frames = r_frames;
  // capture only arrives while idle, so it never races a handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_re     <= '0;
      r_im     <= '0;
      r_busy   <= 1'b0;
      r_idx    <= '0;
      r_frames <= '0;
    end else if (i_capture) begin
      r_re   <= i_yr;
      r_im   <= i_yi;
      r_busy <= 1'b1;
      r_idx  <= '0;
    end else if (r_busy && i_ready) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_busy   <= 1'b0;
        r_frames <= r_frames + 1'b1;
      end
    end
endmodule

// File: rtl/fft32_frame_sequencer.sv
// fft32_frame_sequencer: buffers a 32-sample frame for the combinational FFT core,
// captures its bins after a settle delay and streams them out while the next frame loads
module fft32_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int Q      = FFT_Q,
  parameter int POINTS = FFT_POINTS,
  parameter int SETTLE = 2,
  parameter int IDX_W  = FFT_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_data,
  output logic [POINTS*N-1:0] fft_x,
  input  logic [POINTS*N-1:0] fft_yr,
  input  logic [POINTS*N-1:0] fft_yi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_re,
  output logic [N-1:0]        out_im,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic [15:0]         frames_done
);
  if (Q < 0 || Q >= N || SETTLE < 1 || SETTLE > 15 || POINTS != 32 || (1 << IDX_W) != POINTS) begin : g_bad_cfg
    $error("fft32_frame_sequencer: unsupported parameter set");
  end
  load_state_e              r_state;
  logic [POINTS-1:0][N-1:0] r_bank;
  logic [IDX_W-1:0]         r_fill_cnt;
  logic [3:0]               r_settle_cnt;
  logic                     w_accept;
  logic                     w_capture;
  assign in_ready  = !rst && r_state == FILL;
  assign w_accept  = in_valid && in_ready;
  assign w_capture = r_state == CAPTURE;
  assign fft_x     = r_bank;
  // the bank is only written in FILL, so the core sees a frozen frame until capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= FILL;
      r_bank       <= '0;
      r_fill_cnt   <= '0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        FILL: if (w_accept) begin
          r_bank[r_fill_cnt] <= in_data;
          r_fill_cnt         <= r_fill_cnt == IDX_W'(POINTS - 1) ? '0 : r_fill_cnt + 1'b1;
          if (r_fill_cnt == IDX_W'(POINTS - 1)) r_state <= HOLD;
        end
        HOLD: if (!out_valid) begin
          r_state      <= fft_pkg::SETTLE;
          r_settle_cnt <= '0;
        end
        fft_pkg::SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
          if (r_settle_cnt == 4'(SETTLE - 1)) r_state <= CAPTURE;
        end
        default: r_state <= FILL;
      endcase
    end
  fft_result_unloader #(.N(N), .POINTS(POINTS), .IDX_W(IDX_W)) u_unloader (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_yr      (fft_yr),
    .i_yi      (fft_yi),
    .i_ready   (out_ready),
    .o_valid   (out_valid),
    .o_re      (out_re),
    .o_im      (out_im),
    .o_idx     (out_idx),
    .o_last    (out_last),
    .o_frames  (frames_done)
  );
endmodule
